// File: rtl/hour_scanner_pkg.sv
// hour_scanner_pkg: shared state type for the hour-address sequencer.
package hour_scanner_pkg;
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;
endpackage

// File: rtl/hour_scanner_if.sv
// hour_scanner_if: control inputs and address/strobe outputs of the hour scanner.
interface hour_scanner_if #(parameter int NUM_HOURS = 8);
    localparam int ADDR_W = $clog2(NUM_HOURS);
    logic              en;
    logic              loop;
    logic              pause;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic              step;
    logic              wrap;
    logic              done;
    modport master (output en, loop, pause, input addr, addr_valid, step, wrap, done);
    modport slave  (input en, loop, pause, output addr, addr_valid, step, wrap, done);
endinterface

// File: rtl/hour_scanner_tick_gen.sv
// tick_gen: prescaler emitting one tick per TICK_DIV non-held cycles.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_hold,
    output logic o_tick
);
    localparam int CNT_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_DIV > 1 ? TICK_DIV - 2 : 0);
    localparam logic ONE = TICK_DIV == 1;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;
    // r_last is the registered "count is terminal" flag, so no wide compare feeds o_tick
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt  <= '0;
            r_last <= ONE;
        end else if (!i_hold) begin
            r_cnt  <= r_last ? '0 : r_cnt + CNT_W'(1);
            r_last <= ONE || (!r_last && r_cnt == PRE_LAST);
        end
    end
    assign o_tick = r_last && !i_hold && !i_clear;
endmodule

// File: rtl/hour_scanner.sv
// hour_scanner: steps a RAM read address through NUM_HOURS entries, one per TICK_DIV clocks.
module hour_scanner
    import hour_scanner_pkg::*;
#(
    parameter int NUM_HOURS = 8,
    parameter int TICK_DIV  = 50_000_000
) (
    input logic           clk,
    input logic           reset,
    hour_scanner_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_HOURS);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_HOURS - 1);
    state_t            r_state, w_state;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic              r_valid, r_step, r_wrap, r_done;
    logic              w_step, w_wrap, w_done, w_tick;
    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .i_clear (r_state != S_SCAN || !bus.en),
        .i_hold  (bus.pause),
        .o_tick  (w_tick)
    );
    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_step  = 1'b0;
        w_wrap  = 1'b0;
        w_done  = 1'b0;
        if (!bus.en) begin
            w_state = S_IDLE;
            w_addr  = '0;
        end else begin
            case (r_state)
                S_IDLE: w_state = S_SCAN;
                S_SCAN: if (w_tick) begin
                    // explicit compare so non-power-of-two counts wrap correctly
                    if (r_addr != LAST) begin
                        w_addr = r_addr + ADDR_W'(1);
                        w_step = 1'b1;
                    end else if (bus.loop) begin
                        w_addr = '0;
                        w_step = 1'b1;
                        w_wrap = 1'b1;
                    end else begin
                        w_state = S_DONE;
                        w_done  = 1'b1;
                    end
                end
                default: w_state = r_state;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_valid <= w_state != S_IDLE;
            r_step  <= w_step;
            r_wrap  <= w_wrap;
            r_done  <= w_done;
        end
    end
    assign bus.addr       = r_addr;
    assign bus.addr_valid = r_valid;
    assign bus.step       = r_step;
    assign bus.wrap       = r_wrap;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_hour_scanner.sv
// tb_hour_scanner: directed and random checks of hour_scanner against a dwell-count model.
module tb_hour_scanner;
    localparam int N = 9;
    localparam int T = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   m_st, m_addr, m_cnt, m_step, m_wrap, m_done;
    hour_scanner_if #(.NUM_HOURS(N)) ifa ();
    hour_scanner_if #(.NUM_HOURS(2)) ifb ();
    hour_scanner #(.NUM_HOURS(N), .TICK_DIV(T)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    hour_scanner #(.NUM_HOURS(2), .TICK_DIV(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    // model: m_st 0=idle 1=scanning 2=finished; m_cnt = cycles already spent in current dwell
    task automatic cyc();
        @(posedge clk);
        m_step = 0;
        m_wrap = 0;
        m_done = 0;
        if (reset || !ifa.en) begin
            m_st = 0; m_addr = 0; m_cnt = 0;
        end else if (m_st == 0) begin
            m_st = 1; m_cnt = 0;
        end else if (m_st == 1 && !ifa.pause) begin
            if (m_cnt + 1 < T) m_cnt++;
            else begin
                m_cnt = 0;
                if (m_addr < N - 1) begin m_addr++; m_step = 1; end
                else if (ifa.loop) begin m_addr = 0; m_step = 1; m_wrap = 1; end
                else begin m_st = 2; m_done = 1; end
            end
        end
        #1;
        chk("addr", 32'(ifa.addr), 32'(m_addr));
        chk("addr_valid", 32'(ifa.addr_valid), 32'(m_st != 0));
        chk("step", 32'(ifa.step), 32'(m_step));
        chk("wrap", 32'(ifa.wrap), 32'(m_wrap));
        chk("done", 32'(ifa.done), 32'(m_done));
    endtask
    initial begin
        int n, d, wraps, maxa, prev;
        ifa.en = 0; ifa.loop = 0; ifa.pause = 0;
        ifb.en = 0; ifb.loop = 1; ifb.pause = 0;
        // 1: single pass after reset
        repeat (2) cyc();
        reset = 0;
        ifa.en = 1;
        cyc();
        chk("t1_entry_addr", 32'(ifa.addr), 0);
        n = 0; d = 0;
        while (!ifa.done && n < 60) begin
            if (ifa.addr == 8) d++;
            cyc();
            n++;
        end
        chk("t1_done_seen", 32'(n < 60), 1);
        chk("t1_last_dwell", 32'(d), 4);
        chk("t1_total", 32'(n), N * T);
        cyc();
        chk("t1_done_once", 32'(ifa.done), 0);
        chk("t1_hold_addr", 32'(ifa.addr), 8);
        chk("t1_hold_valid", 32'(ifa.addr_valid), 1);
        // 2: continuous loop wraps 8->0 once in 40 cycles
        ifa.en = 0; cyc();
        ifa.en = 1; ifa.loop = 1; cyc();
        wraps = 0; maxa = 0; prev = 0;
        repeat (40) begin
            cyc();
            if (ifa.wrap) begin
                wraps++;
                chk("t2_wrap_from", 32'(prev), 8);
                chk("t2_wrap_to", 32'(ifa.addr), 0);
            end
            if (int'(ifa.addr) > maxa) maxa = int'(ifa.addr);
            prev = int'(ifa.addr);
        end
        chk("t2_wraps", 32'(wraps), 1);
        chk("t2_max_addr", 32'(maxa), 8);
        // 3: pause 5 cycles mid-dwell of addr 3
        ifa.en = 0; ifa.loop = 0; cyc();
        ifa.en = 1; cyc();
        n = 0;
        while (ifa.addr != 3 && n < 100) begin cyc(); n++; end
        chk("t3_reach", 32'(n < 100), 1);
        d = 1;
        cyc(); if (ifa.addr == 3) d++;
        ifa.pause = 1;
        repeat (5) begin
            cyc();
            if (ifa.addr == 3) d++;
            chk("t3_no_step", 32'(ifa.step), 0);
        end
        ifa.pause = 0;
        n = 0;
        while (ifa.addr == 3 && n < 20) begin cyc(); if (ifa.addr == 3) d++; n++; end
        chk("t3_dwell", 32'(d), 9);
        // 4: en drop on the terminal tick of the last entry
        n = 0;
        while (ifa.addr != 8 && n < 100) begin cyc(); n++; end
        chk("t4_reach", 32'(n < 100), 1);
        repeat (3) cyc();
        ifa.en = 0;
        cyc();
        chk("t4_addr", 32'(ifa.addr), 0);
        chk("t4_valid", 32'(ifa.addr_valid), 0);
        chk("t4_no_done", 32'(ifa.done), 0);
        // 5: finish, drop en one cycle, rescan from 0 with a full dwell
        ifa.en = 1;
        n = 0;
        while (!ifa.done && n < 80) begin cyc(); n++; end
        chk("t5_done_seen", 32'(n < 80), 1);
        ifa.en = 0; cyc();
        ifa.en = 1; cyc();
        chk("t5_restart_addr", 32'(ifa.addr), 0);
        d = 1; n = 0;
        while (ifa.addr == 0 && n < 20) begin cyc(); if (ifa.addr == 0) d++; n++; end
        chk("t5_dwell0", 32'(d), 4);
        // random pause/loop/en activity against the model
        repeat (600) begin
            ifa.pause = ($urandom % 4) == 0;
            if ($urandom % 16 == 0) ifa.loop = $urandom % 2;
            ifa.en = ($urandom % 50) != 0;
            cyc();
        end
        ifa.en = 0; ifa.pause = 0;
        // 6: TICK_DIV=1, two entries, looping
        ifb.en = 1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("t6_addr", 32'(ifb.addr), 32'(i % 2));
            chk("t6_valid", 32'(ifb.addr_valid), 1);
            chk("t6_step", 32'(ifb.step), 32'(i >= 1));
            chk("t6_wrap", 32'(ifb.wrap), 32'(i >= 2 && i % 2 == 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hour_scanner.md
# hour_scanner

Parametrised hour-address sequencer for the parking-lot occupancy RAM. After operating hours end (`en` high), it steps a read address through `NUM_HOURS` entries at one entry per `TICK_DIV` clocks, so a 50 MHz board shows roughly one hour per second. It supports single-pass or continuous-loop scanning, pause, and step/wrap/done strobes. It sits between the control FSM and the RAM read port / HEX display driver.

## Interface

- `NUM_HOURS`, 8: number of RAM entries scanned, addresses 0..NUM_HOURS-1; legal range 2..256; not required to be a power of two.
- `TICK_DIV`, 50_000_000: clocks per address step; legal range ≥1.
- `ADDR_W`, $clog2(NUM_HOURS): derived localparam; not overridden.

Ports (reset reset, synchronous, active-high; clock clk):
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high; clears all state
- `en`  in  1  level; scan requested; low returns block to idle
- `loop`  in  1  1 = wrap to 0 after last entry; 0 = single pass
- `pause`  in  1  freezes prescaler and address while high
- `addr`  out  ADDR_W  RAM read address / current hour
- `addr_valid`  out  1  `addr` is meaningful (state SCAN or DONE)
- `step`  out  1  one-cycle pulse, registered with each `addr` change in SCAN
- `wrap`  out  1  one-cycle pulse when `addr` goes NUM_HOURS-1 → 0
- `done`  out  1  one-cycle pulse on entry to DONE

## Operation

- States: IDLE, SCAN, DONE.
- **IDLE**
  - `addr`=0, `addr_valid`=0, prescaler=0.
  - `en`=1 → SCAN.
- **SCAN**
  - `addr_valid`=1.
  - Prescaler counts 0..TICK_DIV-1 while `pause`=0 and holds while `pause`=1.
  - Terminal tick (prescaler==TICK_DIV-1, `pause`=0), prescaler → 0:
    - `addr` < NUM_HOURS-1: `addr`+1, `step`=1.
    - `addr` == NUM_HOURS-1 and `loop`=1: `addr`=0, `step`=1, `wrap`=1.
    - `addr` == NUM_HOURS-1 and `loop`=0: → DONE, `done`=1, `addr` holds.
- **DONE**
  - `addr` holds NUM_HOURS-1, `addr_valid`=1, no strobes.
  - `en`=0 → IDLE.
- **`en`=0 in any state**: next state IDLE; `addr`, `addr_valid`, prescaler cleared the same edge. This takes priority over a coincident terminal tick (no `step`/`done`).
- `loop` is sampled only at the terminal tick of entry NUM_HOURS-1; changes at other times have no effect.
- Wrap uses explicit compare against NUM_HOURS-1, never natural ADDR_W overflow (e.g. NUM_HOURS=9 wraps 8→0).

## Timing

- Reset: state IDLE; `addr`=0, `addr_valid`=0, `step`=`wrap`=`done`=0, prescaler=0.
- All outputs registered; no combinational input→output paths.
- `en` sampled high at edge k → after edge k+1: SCAN, `addr`=0, `addr_valid`=1.
- With `pause` low, `addr` advances at edges k+1+n·TICK_DIV. Entry 0 dwell equals every other entry's dwell: TICK_DIV cycles.
- Each `pause`-high cycle extends the current dwell by exactly one cycle.
- TICK_DIV=1: `addr` advances every cycle and `step` stays high continuously.
- Single pass: `done` asserts TICK_DIV cycles after `addr` reaches NUM_HOURS-1. Total scan = NUM_HOURS·TICK_DIV cycles from SCAN entry.
- Strobes last exactly one cycle and are never asserted in IDLE.

## Structure

- Package `hour_scanner_pkg`: `state_t` enum {S_IDLE, S_SCAN, S_DONE}.
- Sub-module `tick_gen #(TICK_DIV)`: prescaler with `clear`, `hold` inputs and registered one-cycle `tick` output. TICK_DIV=1 yields `tick` every non-held cycle.
- Top: state register, `addr` counter, strobe registers.

## Test plan

Parameters NUM_HOURS=9, TICK_DIV=4 unless noted.

1. Reset held 2 cycles, then `en`=1, `loop`=0 → `addr` 0..8, each held 4 cycles; `done` pulses once 4 cycles after `addr`=8; `addr` stays 8, `addr_valid`=1.
2. `loop`=1, run 40 cycles → `addr` sequence 8→0 with `wrap`=1 for exactly one cycle; never reaches 9..15.
3. `pause`=1 for 5 cycles mid-dwell of `addr`=3 → that dwell lasts 9 cycles; no `step` during pause.
4. `en`=0 at the cycle of a terminal tick on `addr`=8 with `loop`=0 → next cycle IDLE, `addr`=0, `addr_valid`=0, no `done`.
5. DONE, then `en` low 1 cycle and high again → rescan starts at `addr`=0 with a full 4-cycle dwell.
6. TICK_DIV=1, NUM_HOURS=2, `loop`=1 → `addr` toggles 0,1,0,1 every cycle; `wrap` high every second cycle.
